led_step_controller: RTL and testbench

Control block for the 16-LED brightness ring. It takes the five raw Basys3 buttons, synchronizes and debounces them, and turns them into user commands: slower, faster, pause/resume, direction toggle, and single-step. From these commands it emits a one-cycle `step` strobe that advances the ring's circular shift register, plus the `dir` bit and status outputs. It replaces free-running clock division of the ring with a single-clock, enable-based scheduler.

---
 rtl/led_step_controller_pkg.sv | 22 ++
 rtl/led_step_controller_debounce.sv | 44 ++++
 rtl/led_step_controller.sv | 92 +++++++++
 tb/tb_led_step_controller.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/led_step_controller_pkg.sv
// rtl/led_step_controller_pkg.sv - shared types and constants for the LED ring step controller
package led_ctrl_pkg;

   typedef enum logic {
      RUN    = 1'b0,
      PAUSED = 1'b1
   } ctrl_state_t;

   localparam int BTN_SLOW   = 0;
   localparam int BTN_FAST   = 1;
   localparam int BTN_PAUSE  = 2;
   localparam int BTN_DIR    = 3;
   localparam int BTN_STEP   = 4;
   localparam int NUM_BTNS   = 5;
   localparam int NUM_SPEEDS = 5;

   // Slowest speed (0) gives the longest period: NUM_SPEEDS x base.
   function automatic logic [31:0] step_period(input logic [2:0] speed, input logic [31:0] base);
      return (32'(NUM_SPEEDS) - {29'd0, speed}) * base;
   endfunction

endpackage

// File: rtl/led_step_controller_debounce.sv
// rtl/led_step_controller_debounce.sv - one-button synchronizer, debouncer and rising-edge press detector
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 500_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic press
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic          sync1;
   logic          sync2;
   logic          db;
   logic          db_prev;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         db      <= 1'b0;
         db_prev <= 1'b0;
         cnt     <= '0;
         press   <= 1'b0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
         // Any cycle of agreement restarts the stability window.
         if (sync2 == db) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            db  <= sync2;
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
         db_prev <= db;
         press   <= db & ~db_prev;
      end
   end

endmodule

// File: rtl/led_step_controller.sv
// rtl/led_step_controller.sv - button-driven run/pause scheduler emitting one-cycle ring step strobes
module led_step_controller
   import led_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500_000,
   parameter int BASE_PERIOD     = 1_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] buttons,
   output logic       step,
   output logic       dir,
   output logic       paused,
   output logic [2:0] speed_idx
);

   logic [NUM_BTNS-1:0] press;
   ctrl_state_t         state, state_n;
   logic [31:0]         cnt, cnt_n;
   logic [31:0]         period;
   logic                step_n;
   logic                dir_n;
   logic [2:0]          speed_n;

   for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
      button_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk    (clk),
         .rst    (rst),
         .btn_raw(buttons[i]),
         .press  (press[i])
      );
   end

   assign period = step_period(speed_idx, 32'(BASE_PERIOD));
   assign paused = (state == PAUSED);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RUN;
         cnt       <= '0;
         step      <= 1'b0;
         dir       <= 1'b0;
         speed_idx <= '0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         step      <= step_n;
         dir       <= dir_n;
         speed_idx <= speed_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      step_n  = 1'b0;
      dir_n   = dir ^ press[BTN_DIR];
      speed_n = speed_idx;

      // Opposing speed presses cancel; saturated presses leave speed_n equal.
      if (press[BTN_SLOW] && !press[BTN_FAST] && speed_idx != 3'd0)
         speed_n = speed_idx - 3'd1;
      else if (press[BTN_FAST] && !press[BTN_SLOW] && speed_idx != 3'(NUM_SPEEDS - 1))
         speed_n = speed_idx + 3'd1;

      case (state)
         RUN: begin
            if (press[BTN_PAUSE]) begin
               state_n = PAUSED;
               cnt_n   = '0;
            end else if (speed_n != speed_idx) begin
               cnt_n = '0;
            end else if (cnt == period - 32'd1) begin
               cnt_n  = '0;
               step_n = 1'b1;
            end else begin
               cnt_n = cnt + 32'd1;
            end
         end
         PAUSED: begin
            cnt_n = '0;
            if (press[BTN_PAUSE])
               state_n = RUN;
            else if (press[BTN_STEP])
               step_n = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_led_step_controller.sv
// tb/tb_led_step_controller.sv - directed self-checking bench for led_step_controller
module tb_led_step_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] buttons = '0;
   logic       step;
   logic       dir;
   logic       paused;
   logic [2:0] speed_idx;

   int cyc = 0;
   int step_count = 0;
   int tests = 0;
   int fails = 0;
   int at;
   int n;
   int base;

   led_step_controller #(
      .DEBOUNCE_CYCLES(4),
      .BASE_PERIOD    (10)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .buttons  (buttons),
      .step     (step),
      .dir      (dir),
      .paused   (paused),
      .speed_idx(speed_idx)
   );

   always #5 clk = ~clk;

   // cyc = number of rising edges since reset released
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (!rst && step) step_count <= step_count + 1;
   end

   task automatic idle(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic wait_step(output int t, input int budget);
      int i;
      t = -1;
      i = 0;
      while (t < 0 && i < budget) begin
         @(negedge clk);
         if (step) t = cyc;
         i++;
      end
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      idle(3);
      check("rst_step", step, 0);
      check("rst_dir", dir, 0);
      check("rst_paused", paused, 0);
      check("rst_speed", speed_idx, 0);
      rst = 1'b0;

      wait_step(at, 80);
      check("first_step", at, 50);
      wait_step(at, 80);
      check("second_step", at, 100);
      check("idle_dir", dir, 0);
      check("idle_speed", speed_idx, 0);

      for (int i = 1; i <= 4; i++) begin
         buttons[1] = 1'b1;
         n = cyc;
         idle(6);
         buttons[1] = 1'b0;
         idle(1);
         if (i == 1) check("press_latency_hold", speed_idx, 0);
         idle(1);
         check("speed_up", speed_idx, i);
         wait_step(at, 60);
         check("speed_restart", at, n + 8 + (5 - i) * 10);
      end

      buttons[1] = 1'b1;
      n = cyc;
      idle(6);
      buttons[1] = 1'b0;
      wait_step(at, 30);
      check("sat_no_clear", at, n + 10);
      wait_step(at, 30);
      check("fast_spacing", at, n + 20);
      check("sat_speed", speed_idx, 4);

      buttons[0] = 1'b1;
      idle(3);
      buttons[0] = 1'b0;
      idle(5);
      buttons[0] = 1'b1;
      idle(1);
      buttons[0] = 1'b0;
      idle(20);
      check("glitch_speed", speed_idx, 4);

      buttons[2] = 1'b1;
      n = cyc;
      idle(6);
      buttons[2] = 1'b0;
      idle(2);
      check("paused_set", paused, 1);
      base = step_count;
      idle(60);
      check("paused_no_steps", step_count - base, 0);
      for (int j = 0; j < 2; j++) begin
         buttons[4] = 1'b1;
         n = cyc;
         wait_step(at, 20);
         check("single_step_time", at, n + 8);
         idle(1);
         check("single_step_width", step, 0);
         buttons[4] = 1'b0;
         idle(14);
      end
      check("single_step_count", step_count - base, 2);

      buttons[2] = 1'b1;
      n = cyc;
      idle(6);
      buttons[2] = 1'b0;
      idle(2);
      check("resumed", paused, 0);
      wait_step(at, 30);
      check("resume_full_period", at, n + 18);

      buttons = 5'b00011;
      n = cyc;
      wait_step(at, 30);
      check("both_speed_no_clear", at, n + 10);
      buttons = '0;
      idle(14);
      check("both_speed_idx", speed_idx, 4);

      buttons[3] = 1'b1;
      idle(6);
      buttons[3] = 1'b0;
      idle(2);
      check("dir_toggle", dir, 1);
      idle(10);
      wait_step(at, 30);
      check("pre_reset_step", step, 1);
      #2;
      rst = 1'b1;
      #1;
      check("async_step", step, 0);
      check("async_dir", dir, 0);
      check("async_paused", paused, 0);
      check("async_speed", speed_idx, 0);
      @(negedge clk);
      rst = 1'b0;
      wait_step(at, 80);
      check("post_reset_step", at, 50);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
